// File: rtl/srcnn_mul_pkg.sv
// Shared constants and width/bound helpers for the SRCNN pipelined multiplier.
package srcnn_mul_pkg;

  // Working width for range comparisons; must exceed every product/result width used.
  localparam int MAXW = 128;

  // Operand mode encoding: bit 1 = din0 signed, bit 0 = din1 signed.
  localparam logic [1:0] MODE_UU = 2'b00;
  localparam logic [1:0] MODE_US = 2'b01;
  localparam logic [1:0] MODE_SU = 2'b10;
  localparam logic [1:0] MODE_SS = 2'b11;

  typedef logic signed [MAXW-1:0] wide_t;

  // Full product width: one extension bit per operand, minus the redundant top bit.
  function automatic int fw(input int w0, input int w1);
    return w0 + w1 + 1;
  endfunction

  // Largest two's-complement value of width w.
  function automatic wide_t smax(input int w);
    wide_t one;
    one = wide_t'(1);
    return (one <<< (w - 1)) - one;
  endfunction

  // Smallest two's-complement value of width w.
  function automatic wide_t smin(input int w);
    wide_t one;
    one = wide_t'(1);
    return -(one <<< (w - 1));
  endfunction

  // Largest unsigned value of width w.
  function automatic wide_t umax(input int w);
    wide_t one;
    one = wide_t'(1);
    return (one <<< w) - one;
  endfunction

  // Smallest unsigned value of any width.
  function automatic wide_t umin(input int w);
    wide_t z;
    z = '0;
    return z + wide_t'(w - w);
  endfunction

endpackage

// File: rtl/srcnn_pipe_stage.sv
// One valid+data pipeline register with stall/advance logic; bubbles collapse.
module srcnn_pipe_stage #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         vld_i,
  input  logic [W-1:0] data_i,
  input  logic         adv_next_i,
  output logic         vld_o,
  output logic [W-1:0] data_o,
  output logic         adv_o
);

  logic         vld_q, vld_d;
  logic [W-1:0] data_q, data_d;

  // The stage may take new contents when it is empty or its contents move on.
  assign adv_o  = !vld_q | adv_next_i;
  assign vld_o  = vld_q;
  assign data_o = data_q;

  // Next state: load on advance; data only changes when a valid item enters.
  always_comb begin
    vld_d  = vld_q;
    data_d = data_q;
    if (adv_o) begin
      vld_d = vld_i;
      if (vld_i) data_d = data_i;
    end
  end

  // State register; reset clears both valid and data.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vld_q  <= 1'b0;
      data_q <= '0;
    end else begin
      vld_q  <= vld_d;
      data_q <= data_d;
    end
  end

endmodule

// File: rtl/srcnn_mul_pipe.sv
// Pipelined integer multiplier with per-operand signedness, valid/ready
// handshake and wrap/saturate output formatting. NUM_STAGE must be >= 2.
module srcnn_mul_pipe
  import srcnn_mul_pkg::*;
#(
  parameter int DIN0_WIDTH = 14,
  parameter int DIN1_WIDTH = 12,
  parameter int DOUT_WIDTH = 26,
  parameter int NUM_STAGE  = 3,
  parameter int SATURATE   = 0
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DIN0_WIDTH-1:0] din0,
  input  logic [DIN1_WIDTH-1:0] din1,
  input  logic                  din0_signed,
  input  logic                  din1_signed,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DOUT_WIDTH-1:0] dout,
  output logic                  ovf
);

  localparam int FW  = fw(DIN0_WIDTH, DIN1_WIDTH);
  localparam int S1W = DIN0_WIDTH + DIN1_WIDTH + 2;
  localparam int RW  = DOUT_WIDTH + 1;

  // Exact product of the two extended operands; fits FW bits for every mode.
  function automatic logic signed [FW-1:0] mul_ext(
    input logic [DIN0_WIDTH-1:0] a,
    input logic [DIN1_WIDTH-1:0] b,
    input logic                  sa,
    input logic                  sb
  );
    logic signed [DIN0_WIDTH:0] ax;
    logic signed [DIN1_WIDTH:0] bx;
    logic signed [FW-1:0]       ae, be;
    ax = {sa & a[DIN0_WIDTH-1], a};
    bx = {sb & b[DIN1_WIDTH-1], b};
    ae = FW'(ax);
    be = FW'(bx);
    return ae * be;
  endfunction

  // Format the product into {ovf, dout}: extend, wrap or clamp.
  function automatic logic [RW-1:0] fmt(input logic signed [FW-1:0] p, input logic sgn);
    wide_t                 pw, zw, hi, lo;
    logic                  o;
    logic [DOUT_WIDTH-1:0] d;
    pw = wide_t'(p);
    zw = wide_t'($unsigned(p));
    if (DOUT_WIDTH >= FW) begin
      o = 1'b0;
      d = sgn ? pw[DOUT_WIDTH-1:0] : zw[DOUT_WIDTH-1:0];
    end else begin
      hi = sgn ? smax(DOUT_WIDTH) : umax(DOUT_WIDTH);
      lo = sgn ? smin(DOUT_WIDTH) : umin(DOUT_WIDTH);
      o  = (pw > hi) || (pw < lo);
      if ((SATURATE != 0) && o) d = (pw > hi) ? hi[DOUT_WIDTH-1:0] : lo[DOUT_WIDTH-1:0];
      else                      d = pw[DOUT_WIDTH-1:0];
    end
    return {o, d};
  endfunction

  logic                  vld [0:NUM_STAGE];
  logic                  adv [1:NUM_STAGE+1];
  logic [RW-1:0]         res [2:NUM_STAGE];

  logic [S1W-1:0]        op_p0, op_p1;
  logic [1:0]            mode_p1;
  logic [DIN0_WIDTH-1:0] a_p1;
  logic [DIN1_WIDTH-1:0] b_p1;
  logic                  sa_p1, sb_p1, sgn_p1;
  logic signed [FW-1:0]  prod_p1;
  logic [RW-1:0]         fmt_p1;

  // Input side: ready is held low during reset and otherwise follows stage-1 advance.
  assign in_ready            = ap_rst_n & adv[1];
  assign vld[0]              = in_valid & in_ready;
  assign op_p0               = {din0_signed, din1_signed, din1, din0};
  assign adv[NUM_STAGE+1]    = out_ready;

  // ---- stage 1: operands and mode bits registered ----
  srcnn_pipe_stage #(.W(S1W)) u_stage1 (
    .clk_i      (ap_clk),
    .rst_ni     (ap_rst_n),
    .vld_i      (vld[0]),
    .data_i     (op_p0),
    .adv_next_i (adv[2]),
    .vld_o      (vld[1]),
    .data_o     (op_p1),
    .adv_o      (adv[1])
  );

  assign a_p1    = op_p1[DIN0_WIDTH-1:0];
  assign b_p1    = op_p1[DIN0_WIDTH +: DIN1_WIDTH];
  assign mode_p1 = op_p1[S1W-1 -: 2];
  assign sa_p1   = (mode_p1 == MODE_SU) || (mode_p1 == MODE_SS);
  assign sb_p1   = (mode_p1 == MODE_US) || (mode_p1 == MODE_SS);
  assign sgn_p1  = (mode_p1 != MODE_UU);
  assign prod_p1 = mul_ext(a_p1, b_p1, sa_p1, sb_p1);
  assign fmt_p1  = fmt(prod_p1, sgn_p1);

  // ---- stage 2: formatted result registered; stages 3..NUM_STAGE delay only ----
  for (genvar k = 2; k <= NUM_STAGE; k++) begin : g_stage
    logic [RW-1:0] din_k;
    if (k == 2) begin : g_first
      assign din_k = fmt_p1;
    end else begin : g_delay
      assign din_k = res[k-1];
    end
    srcnn_pipe_stage #(.W(RW)) u_stage (
      .clk_i      (ap_clk),
      .rst_ni     (ap_rst_n),
      .vld_i      (vld[k-1]),
      .data_i     (din_k),
      .adv_next_i (adv[k+1]),
      .vld_o      (vld[k]),
      .data_o     (res[k]),
      .adv_o      (adv[k])
    );
  end

  assign out_valid = vld[NUM_STAGE];
  assign dout      = res[NUM_STAGE][DOUT_WIDTH-1:0];
  assign ovf       = res[NUM_STAGE][DOUT_WIDTH];

endmodule

// File: tb/tb_srcnn_mul_pipe.sv
// Bench for srcnn_mul_pipe: three instances (default, 16-bit saturating,
// 16-bit wrapping) driven in lock-step and compared to an arithmetic model.
module tb_srcnn_mul_pipe;

  localparam int NS = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic        s0 = 1'b0, s1 = 1'b0;
  logic [13:0] din0 = '0;
  logic [11:0] din1 = '0;

  logic        in_ready_a, in_ready_b, in_ready_c;
  logic        ov_a, ov_b, ov_c;
  logic        ovf_a, ovf_b, ovf_c;
  logic [25:0] dout_a;
  logic [15:0] dout_b, dout_c;

  always #5 clk = ~clk;

  srcnn_mul_pipe u_dut (
    .ap_clk(clk), .ap_rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_a),
    .din0(din0), .din1(din1), .din0_signed(s0), .din1_signed(s1),
    .out_valid(ov_a), .out_ready(out_ready), .dout(dout_a), .ovf(ovf_a)
  );

  srcnn_mul_pipe #(.DOUT_WIDTH(16), .SATURATE(1)) u_sat (
    .ap_clk(clk), .ap_rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_b),
    .din0(din0), .din1(din1), .din0_signed(s0), .din1_signed(s1),
    .out_valid(ov_b), .out_ready(out_ready), .dout(dout_b), .ovf(ovf_b)
  );

  srcnn_mul_pipe #(.DOUT_WIDTH(16), .SATURATE(0)) u_wrap (
    .ap_clk(clk), .ap_rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_c),
    .din0(din0), .din1(din1), .din0_signed(s0), .din1_signed(s1),
    .out_valid(ov_c), .out_ready(out_ready), .dout(dout_c), .ovf(ovf_c)
  );

  typedef struct {
    logic [63:0] ea;
    logic [63:0] eb;
    logic [63:0] ec;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   n_out = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Operand value as an integer given its width and signedness.
  function automatic longint opval(input logic [31:0] v, input int w, input bit sg);
    longint x;
    x = longint'(v);
    if (sg && v[w-1]) x = x - (longint'(1) << w);
    return x;
  endfunction

  // Expected {ovf, dout} for product p, result signedness sg, width w, saturate flag.
  function automatic logic [63:0] fmt_ref(input longint p, input bit sg, input int w, input bit sat);
    longint hi, lo, r, m;
    bit     o;
    hi = sg ? (longint'(1) << (w - 1)) - 1 : (longint'(1) << w) - 1;
    lo = sg ? -(longint'(1) << (w - 1)) : 0;
    o  = (p > hi) || (p < lo);
    r  = p;
    if (sat && o) r = (p > hi) ? hi : lo;
    m  = (longint'(1) << w) - 1;
    return 64'(r & m) | (64'(o) << w);
  endfunction

  function automatic logic [31:0] pick(input int w);
    logic [31:0] m;
    m = (32'd1 << w) - 32'd1;
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return m;
      2:       return 32'd1 << (w - 1);
      3:       return (32'd1 << (w - 1)) - 32'd1;
      default: return $urandom & m;
    endcase
  endfunction

  // Scoreboard: record each accepted op, compare each presented result with the oldest.
  always @(negedge clk) begin : mon
    longint p;
    bit     sg;
    exp_t   e;
    if (rst_n) begin
      if (ov_a) begin
        if (exp_q.size() == 0) chk("spurious_out", 64'(ov_a), 64'd0);
        else begin
          chk("res_a", 64'({ovf_a, dout_a}), exp_q[0].ea);
          chk("res_b", 64'({ovf_b, dout_b}), exp_q[0].eb);
          chk("res_c", 64'({ovf_c, dout_c}), exp_q[0].ec);
          if (out_ready) begin
            exp_q.delete(0);
            n_out++;
          end
        end
      end
      if (in_valid && in_ready_a) begin
        p  = opval(32'(din0), 14, s0) * opval(32'(din1), 12, s1);
        sg = s0 | s1;
        e.ea = fmt_ref(p, sg, 26, 1'b0);
        e.eb = fmt_ref(p, sg, 16, 1'b1);
        e.ec = fmt_ref(p, sg, 16, 1'b0);
        exp_q.push_back(e);
      end
    end
  end

  // Single op into an empty pipe; checks the latency and returns at the due negedge.
  task automatic one_op(input logic [13:0] a, input logic [11:0] b, input bit sa, input bit sb);
    @(posedge clk); #1;
    in_valid = 1'b1; din0 = a; din1 = b; s0 = sa; s1 = sb; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int k = 1; k < NS; k++) begin
      @(negedge clk);
      chk("lat_early", 64'(ov_a), 64'd0);
    end
    @(negedge clk);
    chk("lat_due", 64'(ov_a), 64'd1);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int idx, sent, out0;
    bit acc;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 64'(in_ready_a), 64'd0);
    chk("rst_out_valid", 64'(ov_a), 64'd0);
    chk("rst_dout", 64'(dout_a), 64'd0);
    chk("rst_ovf", 64'(ovf_a), 64'd0);
    #2 rst_n = 1'b1;
    #1 chk("rel_in_ready", 64'(in_ready_a), 64'd1);

    // Directed products
    one_op(14'd16383, 12'd4095, 1'b0, 1'b0);
    chk("uu_max", 64'({ovf_a, dout_a}), 64'd67088385);
    one_op(14'h3FFF, 12'd4095, 1'b1, 1'b0);
    chk("su_neg", 64'({ovf_a, dout_a}), 64'h3FFF001);
    one_op(14'h2000, 12'h800, 1'b1, 1'b1);
    chk("ss_min", 64'({ovf_a, dout_a}), 64'd16777216);
    one_op(14'd300, 12'd300, 1'b0, 1'b0);
    chk("sat_uu", 64'({ovf_b, dout_b}), 64'h1FFFF);
    chk("wrap_uu", 64'({ovf_c, dout_c}), 64'h15F90);
    chk("wide_uu", 64'({ovf_a, dout_a}), 64'd90000);
    one_op(14'h2000, 12'd2047, 1'b1, 1'b0);
    chk("sat_su", 64'({ovf_b, dout_b}), 64'h18000);

    // Back-to-back stream with a 5-cycle output stall
    @(posedge clk); #1;
    out0 = n_out; idx = 0; acc = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if (acc) idx++;
      in_valid  = (idx < 8);
      din0      = 14'(idx);
      din1      = 12'(idx + 1);
      s0        = 1'b0;
      s1        = 1'b0;
      out_ready = !(c >= 5 && c < 10);
      @(negedge clk);
      acc = in_valid && in_ready_a;
      if (c >= 5 && c < 10) begin
        chk("stall_in_ready", 64'(in_ready_a), 64'd0);
        chk("stall_dout", 64'(dout_a), 64'd6);
      end
    end
    in_valid = 1'b0;
    chk("stream_count", 64'(n_out - out0), 64'd8);
    chk("stream_empty", 64'(exp_q.size()), 64'd0);

    // Randomized traffic
    sent = 0; acc = 1'b0;
    for (int c = 0; c < 60000 && sent < 10000; c++) begin
      @(posedge clk); #1;
      if (acc) sent++;
      in_valid  = (sent < 10000) && ($urandom_range(0, 1) == 1);
      din0      = 14'(pick(14));
      din1      = 12'(pick(12));
      s0        = 1'($urandom_range(0, 1));
      s1        = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      acc = in_valid && in_ready_a;
    end
    chk("rand_sent", 64'(sent), 64'd10000);
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b1;
    for (int c = 0; c < 20 && exp_q.size() != 0; c++) @(negedge clk);
    chk("rand_drain", 64'(exp_q.size()), 64'd0);

    // Asynchronous reset with three ops in flight
    @(posedge clk); #1;
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1; din0 = 14'(100 + k); din1 = 12'd7; s0 = 1'b0; s1 = 1'b0;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    chk("fill_valid", 64'(ov_a), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", 64'(ov_a), 64'd0);
    chk("arst_dout", 64'(dout_a), 64'd0);
    chk("arst_ovf", 64'(ovf_a), 64'd0);
    chk("arst_in_ready", 64'(in_ready_a), 64'd0);
    exp_q.delete();
    @(posedge clk); #3;
    rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (6) begin
      @(negedge clk);
      chk("no_stale", 64'(ov_a), 64'd0);
    end
    one_op(14'd9, 12'd11, 1'b0, 1'b0);
    chk("post_rst_op", 64'({ovf_a, dout_a}), 64'd99);
    @(posedge clk); #1;

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
